// File: rtl/uart_v3_if.sv
// uart_v3 byte-level handshake bundle.
// Host logic uses master, the UART uses slave.
interface uart_v3_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting;
  logic [7:0] rx_byte;
  logic       received;
  logic       rx_parity_error;
  logic       rx_frame_error;
  logic       is_receiving;

  modport master (
    output transmit, tx_byte,
    input  is_transmitting, rx_byte, received,
    input  rx_parity_error, rx_frame_error, is_receiving
  );

  modport slave (
    input  transmit, tx_byte,
    output is_transmitting, rx_byte, received,
    output rx_parity_error, rx_frame_error, is_receiving
  );
endinterface

// File: rtl/uart_v3.sv
// Configurable full-duplex UART: 5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits, synchronised and majority-voted receiver.
module uart_v3 #(
    parameter int OVERSAMPLE        = 16,
    parameter int DIV_WIDTH         = 16,
    parameter int DEFAULT_CLOCK_DIV = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_clock_div,
    input  logic [DIV_WIDTH-1:0] user_clock_div,
    output logic [DIV_WIDTH-1:0] clock_div,
    input  logic [3:0]           cfg_data_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx,
    input  logic                 rx,
    uart_v3_if.slave             bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] MIDM = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MIDP = TW'(OVERSAMPLE / 2 + 1);

    localparam logic [2:0] T_IDLE  = 3'd0;
    localparam logic [2:0] T_START = 3'd1;
    localparam logic [2:0] T_DATA  = 3'd2;
    localparam logic [2:0] T_PAR   = 3'd3;
    localparam logic [2:0] T_STOP1 = 3'd4;
    localparam logic [2:0] T_STOP2 = 3'd5;

    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_PAR   = 3'd3;
    localparam logic [2:0] R_STOP  = 3'd4;
    localparam logic [2:0] R_WAIT  = 3'd5;

    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b < 4'd5) return 4'd5;
        if (b > 4'd8) return 4'd8;
        return b;
    endfunction

    logic clr;
    assign clr = rst | set_clock_div;

    always_ff @(posedge clk) begin
        if (rst) clock_div <= DIV_WIDTH'(DEFAULT_CLOCK_DIV);
        else if (set_clock_div) clock_div <= user_clock_div;
    end

    // ---------------- transmitter ----------------
    logic [2:0]           t_state;
    logic [DIV_WIDTH-1:0] t_cnt;
    logic [TW-1:0]        t_tk;
    logic [2:0]           t_bit;
    logic [7:0]           t_sh;
    logic [3:0]           t_n;
    logic                 t_par_en, t_par, t_stop2;
    logic                 t_tick;
    logic [3:0]           n_cfg;
    logic [7:0]           tx_data;

    assign t_tick  = (t_cnt == '0);
    assign n_cfg   = clamp_bits(cfg_data_bits);
    assign tx_data = bus.tx_byte & (8'hFF >> (4'd8 - n_cfg));

    always_ff @(posedge clk) begin
        if (clr) begin
            t_state  <= T_IDLE;
            t_cnt    <= '0;
            t_tk     <= '0;
            t_bit    <= '0;
            t_sh     <= '0;
            t_n      <= 4'd8;
            t_par_en <= 1'b0;
            t_par    <= 1'b0;
            t_stop2  <= 1'b0;
        end else begin
            t_cnt <= t_tick ? clock_div : t_cnt - 1'b1;
            if (t_state == T_IDLE) begin
                if (bus.transmit) begin
                    t_state  <= T_START;
                    t_cnt    <= clock_div;
                    t_tk     <= '0;
                    t_bit    <= '0;
                    t_sh     <= tx_data;
                    t_n      <= n_cfg;
                    t_par_en <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
                    t_par    <= (^tx_data) ^ (cfg_parity == 2'd2);
                    t_stop2  <= cfg_stop2;
                end
            end else if (t_tick) begin
                t_tk <= t_tk + 1'b1;
                if (t_tk == LAST) begin
                    t_tk <= '0;
                    unique case (t_state)
                        T_START: t_state <= T_DATA;
                        T_DATA: begin
                            t_sh  <= t_sh >> 1;
                            t_bit <= t_bit + 1'b1;
                            if ({1'b0, t_bit} == t_n - 4'd1)
                                t_state <= t_par_en ? T_PAR : T_STOP1;
                        end
                        T_PAR:   t_state <= T_STOP1;
                        T_STOP1: t_state <= t_stop2 ? T_STOP2 : T_IDLE;
                        default: t_state <= T_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (t_state)
            T_START: tx = 1'b0;
            T_DATA:  tx = t_sh[0];
            T_PAR:   tx = t_par;
            default: tx = 1'b1;
        endcase
    end

    assign bus.is_transmitting = (t_state != T_IDLE);

    // ---------------- receiver ----------------
    logic [2:0]           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [TW-1:0]        r_tk;
    logic [2:0]           r_bit;
    logic [7:0]           r_sh;
    logic [3:0]           r_n;
    logic                 r_par_en, r_odd, r_par_bit;
    logic                 rx_m, rxs, s0, s1, maj, r_tick;

    assign r_tick = (r_cnt == '0);
    assign maj    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state             <= R_IDLE;
            r_cnt               <= '0;
            r_tk                <= '0;
            r_bit               <= '0;
            r_sh                <= '0;
            r_n                 <= 4'd8;
            r_par_en            <= 1'b0;
            r_odd               <= 1'b0;
            r_par_bit           <= 1'b0;
            rx_m                <= 1'b1;
            rxs                 <= 1'b1;
            s0                  <= 1'b1;
            s1                  <= 1'b1;
            bus.rx_byte         <= '0;
            bus.received        <= 1'b0;
            bus.rx_parity_error <= 1'b0;
            bus.rx_frame_error  <= 1'b0;
        end else begin
            rx_m                <= rx;
            rxs                 <= rx_m;
            bus.received        <= 1'b0;
            bus.rx_parity_error <= 1'b0;
            bus.rx_frame_error  <= 1'b0;
            r_cnt <= r_tick ? clock_div : r_cnt - 1'b1;
            unique case (r_state)
                R_IDLE: begin
                    if (!rxs) begin
                        r_state  <= R_START;
                        r_cnt    <= clock_div;
                        r_tk     <= '0;
                        r_bit    <= '0;
                        r_sh     <= '0;
                        r_n      <= n_cfg;
                        r_par_en <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
                        r_odd    <= (cfg_parity == 2'd2);
                    end
                end
                R_WAIT: if (rxs) r_state <= R_IDLE;
                default: if (r_tick) begin
                    r_tk <= r_tk + 1'b1;
                    if (r_tk == MIDM) s0 <= rxs;
                    if (r_tk == MID) s1 <= rxs;
                    if (r_state == R_START) begin
                        if (r_tk == MID && rxs) r_state <= R_IDLE;
                        else if (r_tk == LAST) begin
                            r_state <= R_DATA;
                            r_tk    <= '0;
                        end
                    end else if (r_state == R_DATA) begin
                        if (r_tk == MIDP) r_sh <= {maj, r_sh[7:1]};
                        if (r_tk == LAST) begin
                            r_tk  <= '0;
                            r_bit <= r_bit + 1'b1;
                            if ({1'b0, r_bit} == r_n - 4'd1)
                                r_state <= r_par_en ? R_PAR : R_STOP;
                        end
                    end else if (r_state == R_PAR) begin
                        if (r_tk == MIDP) r_par_bit <= maj;
                        if (r_tk == LAST) begin
                            r_tk    <= '0;
                            r_state <= R_STOP;
                        end
                    end else if (r_tk == MIDP) begin
                        // leave early so a following start edge is caught
                        r_tk <= '0;
                        if (maj) begin
                            r_state             <= R_IDLE;
                            bus.rx_byte         <= r_sh >> (4'd8 - r_n);
                            bus.received        <= 1'b1;
                            bus.rx_parity_error <= r_par_en &&
                                (r_par_bit != ((^r_sh) ^ r_odd));
                        end else begin
                            r_state            <= R_WAIT;
                            bus.rx_frame_error <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.is_receiving = (r_state != R_IDLE);
endmodule
